hb_cell: RTL and testbench
==========================

# hb_cell

- Clocked half-bridge driver cell for one MicroMotorSequencer driver output pair.
- Takes the pad-level gate commands `p_in`/`n_in`, resynchronises them, enforces break-before-make, and produces a registered line drive (`line_o`/`line_oe`) that the dot-matrix row/column decode consumes.
- Detects shoot-through requests (both switches commanded on), forces the line to high-Z, and latches a sticky fault with a saturating event counter.

## Interface
- `DEAD_TIME`, 4: cycles both switches are held off between opposite driven states; legal range 1..255.
- `FAULT_CNT_W`, 8: width of the fault event counter.
- `clock`  in  1  sole clock; every flop is rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `p_in`  in  1  high-side gate command, active-low (0 = high side on).
- `n_in`  in  1  low-side gate command, active-high (1 = low side on).
- `fault_clear`  in  1  single-cycle request to leave FAULT.
- `line_o`  out  1  drive value; 1 in HIGH, 0 otherwise.
- `line_oe`  out  1  drive enable; 1 in HIGH or LOW.
- `state`  out  2  line state: 00 HIZ, 01 LOW, 10 HIGH, 11 FAULT. DEAD reports 00.
- `fault`  out  1  sticky fault flag.
- `fault_count`  out  FAULT_CNT_W  number of FAULT entries, saturating.

## Operation
- **Synchronisation.** `p_in` and `n_in` each pass through a 2-flop synchroniser.
  - Reset values are inactive: p = 1, n = 0.
  - Decoded requests: hs_req = ~p_sync, ls_req = n_sync.
  - Request code: NONE (neither), HI (hs only), LO (ls only), BOTH.
- **FSM states.** HIZ, DEAD, HIGH, LOW, FAULT. Reset state is HIZ.
- **BOTH has top priority.** From any non-FAULT state a BOTH request moves to FAULT.
- **HIZ transitions.**
  - HI → HIGH.
  - LO → LOW.
  - NONE → stay in HIZ.
- **HIGH transitions.**
  - HI → stay.
  - NONE → HIZ.
  - LO → DEAD, with the dead counter loaded to DEAD_TIME-1.
- **LOW transitions.** Mirror of HIGH: LO → stay, NONE → HIZ, HI → DEAD.
- **DEAD.** The line is off and the counter decrements each cycle. At counter = 0 the FSM re-evaluates the request: HI → HIGH, LO → LOW, NONE → HIZ. A NONE request during DEAD goes to HIZ immediately.
- **FAULT.**
  - On entry: `fault` is set, and `fault_count` increments once per entry, saturating at all-ones.
  - Exit: only on `fault_clear`=1 with the request equal to NONE, going to HIZ and clearing `fault`. With any other request the FSM stays in FAULT.
  - `fault_clear` outside FAULT has no effect.
- **Output registers.** Outputs are registered from the next state. No direct HIGH↔LOW transition exists.

## Timing
- Reset values: `line_o`=0, `line_oe`=0, `state`=00, `fault`=0, `fault_count`=0, dead counter = 0, synchronisers inactive.
- Latency is 3 cycles from a pad edge to the output change: 2 synchroniser cycles plus 1 output register.
- HIGH→LOW costs exactly DEAD_TIME cycles with `line_oe`=0 before LOW is driven.
- A new fault arriving in the same cycle as `fault_clear` keeps the FSM in FAULT; the counter does not increment again.
- `reset` asserted mid-DEAD or mid-FAULT returns to the full reset values on the next edge.

## Configuration
- Macro: `HB_CELL_DEADTIME_EN`.
- **Defined:** DEAD state and counter exist as described above.
- **Undefined:**
  - DEAD and the counter are removed; HIGH↔LOW switches in one cycle.
  - `DEAD_TIME` is ignored.
  - Fault detection is unchanged.

## Structure
- Shared package `hb_cell_pkg` holds:
  - the state enum typedef;
  - the 2-bit `state` encoding constants;
  - the request-code constants.
- One sub-module, `hb_cell_sync`: the 2-flop synchroniser with a reset value parameter, instantiated twice.

## Test plan
- **Reset.** `reset` high for 5 cycles → all outputs 0, `state`=00.
- **Drive high.** p_in=0, n_in=0 from HIZ → `line_oe`=1 and `line_o`=1 on the 3rd edge.
- **Break-before-make.** HIGH, then p_in=1, n_in=1 with DEAD_TIME=4 → `line_oe`=0 for exactly 4 cycles, then LOW (`line_oe`=1, `line_o`=0).
- **Shoot-through.** p_in=0, n_in=1 → FAULT: `state`=11, `fault`=1, `fault_count`=1, `line_oe`=0.
  - `fault_clear` while the request is still BOTH → remains FAULT.
  - Set the request to NONE, then `fault_clear` → HIZ with `fault`=0.
- **Counter saturation.** 300 fault entries with FAULT_CNT_W=8 → `fault_count`=255.
- **Macro off.** Build without `HB_CELL_DEADTIME_EN`; HIGH → LO request → LOW on the next register update with no off gap.

Source files
------------

// File: rtl/hb_cell_pkg.sv
// rtl/hb_cell_pkg.sv - shared state enum, line-state encoding and request codes for hb_cell
package hb_cell_pkg;

  typedef enum logic [2:0] {
    ST_HIZ,
    ST_DEAD,
    ST_HIGH,
    ST_LOW,
    ST_FAULT
  } hb_state_e;

  localparam logic [1:0] STATE_HIZ   = 2'b00;
  localparam logic [1:0] STATE_LOW   = 2'b01;
  localparam logic [1:0] STATE_HIGH  = 2'b10;
  localparam logic [1:0] STATE_FAULT = 2'b11;

  // Request code is {ls_req, hs_req}
  localparam logic [1:0] REQ_NONE = 2'b00;
  localparam logic [1:0] REQ_HI   = 2'b01;
  localparam logic [1:0] REQ_LO   = 2'b10;
  localparam logic [1:0] REQ_BOTH = 2'b11;

  function automatic logic [1:0] state_code(input hb_state_e st);
    case (st)
      ST_HIGH:  return STATE_HIGH;
      ST_LOW:   return STATE_LOW;
      ST_FAULT: return STATE_FAULT;
      default:  return STATE_HIZ;
    endcase
  endfunction

endpackage

// File: rtl/hb_cell_sync.sv
// rtl/hb_cell_sync.sv - 2-flop synchroniser for one pad-level gate command
// RESET_VAL is the inactive level of the command it carries.
module hb_cell_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/hb_cell.sv
// rtl/hb_cell.sv - half-bridge driver cell: break-before-make FSM with shoot-through fault latch
// HB_CELL_DEADTIME_EN enables the DEAD state and dead-time counter; otherwise HIGH<->LOW is direct.
module hb_cell
  import hb_cell_pkg::*;
#(
  parameter int DEAD_TIME   = 4,
  parameter int FAULT_CNT_W = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   p_in,
  input  logic                   n_in,
  input  logic                   fault_clear,
  output logic                   line_o,
  output logic                   line_oe,
  output logic [1:0]             state,
  output logic                   fault,
  output logic [FAULT_CNT_W-1:0] fault_count
);

  logic p_sync, n_sync;

  hb_cell_sync #(.RESET_VAL(1'b1)) u_sync_p (
    .clock(clock), .reset(reset), .d(p_in), .q(p_sync)
  );

  hb_cell_sync #(.RESET_VAL(1'b0)) u_sync_n (
    .clock(clock), .reset(reset), .d(n_in), .q(n_sync)
  );

  logic [1:0] req;
  assign req = {n_sync, ~p_sync};

  hb_state_e              st_q, st_d;
  logic                   line_o_q, line_o_d;
  logic                   line_oe_q, line_oe_d;
  logic [1:0]             state_q, state_d;
  logic                   fault_q, fault_d;
  logic [FAULT_CNT_W-1:0] count_q, count_d;

`ifdef HB_CELL_DEADTIME_EN
  localparam logic [7:0] DEAD_LOAD = 8'(DEAD_TIME - 1);
  logic [7:0] dead_q, dead_d;
`endif

  always_comb begin
    st_d = st_q;
`ifdef HB_CELL_DEADTIME_EN
    dead_d = dead_q;
`endif
    if (st_q == ST_FAULT) begin
      if (fault_clear && (req == REQ_NONE)) st_d = ST_HIZ;
    end else if (req == REQ_BOTH) begin
      st_d = ST_FAULT;
    end else if (req == REQ_NONE) begin
      st_d = ST_HIZ;
    end else begin
      case (st_q)
        ST_HIGH: begin
          if (req == REQ_LO) begin
`ifdef HB_CELL_DEADTIME_EN
            st_d   = ST_DEAD;
            dead_d = DEAD_LOAD;
`else
            st_d = ST_LOW;
`endif
          end
        end
        ST_LOW: begin
          if (req == REQ_HI) begin
`ifdef HB_CELL_DEADTIME_EN
            st_d   = ST_DEAD;
            dead_d = DEAD_LOAD;
`else
            st_d = ST_HIGH;
`endif
          end
        end
`ifdef HB_CELL_DEADTIME_EN
        ST_DEAD: begin
          if (dead_q == 8'd0) st_d = (req == REQ_HI) ? ST_HIGH : ST_LOW;
          else                dead_d = dead_q - 8'd1;
        end
`endif
        default: st_d = (req == REQ_HI) ? ST_HIGH : ST_LOW;
      endcase
    end

    // Outputs are registered from the next state, so they track st_q exactly
    line_o_d  = (st_d == ST_HIGH);
    line_oe_d = (st_d == ST_HIGH) || (st_d == ST_LOW);
    state_d   = state_code(st_d);
    fault_d   = (st_d == ST_FAULT);
    count_d   = count_q;
    if ((st_d == ST_FAULT) && (st_q != ST_FAULT) && (count_q != {FAULT_CNT_W{1'b1}}))
      count_d = count_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      st_q      <= ST_HIZ;
      line_o_q  <= 1'b0;
      line_oe_q <= 1'b0;
      state_q   <= STATE_HIZ;
      fault_q   <= 1'b0;
      count_q   <= '0;
`ifdef HB_CELL_DEADTIME_EN
      dead_q    <= 8'd0;
`endif
    end else begin
      st_q      <= st_d;
      line_o_q  <= line_o_d;
      line_oe_q <= line_oe_d;
      state_q   <= state_d;
      fault_q   <= fault_d;
      count_q   <= count_d;
`ifdef HB_CELL_DEADTIME_EN
      dead_q    <= dead_d;
`endif
    end
  end

  assign line_o      = line_o_q;
  assign line_oe     = line_oe_q;
  assign state       = state_q;
  assign fault       = fault_q;
  assign fault_count = count_q;

endmodule

// File: tb/tb_hb_cell.sv
// tb/tb_hb_cell.sv - randomized self-checking bench for hb_cell against a behavioural line model
module tb_hb_cell;

  localparam int DEAD_TIME   = 4;
  localparam int FAULT_CNT_W = 8;
  localparam int CNT_MAX     = (1 << FAULT_CNT_W) - 1;
  localparam int VW          = FAULT_CNT_W + 5;
`ifdef HB_CELL_DEADTIME_EN
  localparam bit DEAD_EN = 1'b1;
`else
  localparam bit DEAD_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic p_in = 1'b1;
  logic n_in = 1'b0;
  logic fault_clear = 1'b0;
  logic line_o, line_oe, fault;
  logic [1:0] state;
  logic [FAULT_CNT_W-1:0] fault_count;

  hb_cell #(.DEAD_TIME(DEAD_TIME), .FAULT_CNT_W(FAULT_CNT_W)) dut (
    .clock(clock), .reset(reset), .p_in(p_in), .n_in(n_in),
    .fault_clear(fault_clear), .line_o(line_o), .line_oe(line_oe),
    .state(state), .fault(fault), .fault_count(fault_count)
  );

  always #5 clock = ~clock;

  logic [VW-1:0] dut_v;
  assign dut_v = {line_o, line_oe, state, fault, fault_count};

  int checks = 0;
  int errors = 0;

  // Behavioural model: what the line is doing, plus a pending off-gap deadline
  bit  pipe_p [2];
  bit  pipe_n [2];
  byte m_line;
  bit  m_fault;
  bit  m_gap;
  int  m_gap_end;
  int  m_cnt;
  int  cyc;

  task automatic model_step();
    bit hs, ls;
    byte want;
    cyc++;
    if (reset) begin
      pipe_p[0] = 1'b1; pipe_p[1] = 1'b1;
      pipe_n[0] = 1'b0; pipe_n[1] = 1'b0;
      m_line = "Z"; m_fault = 1'b0; m_gap = 1'b0; m_cnt = 0;
      return;
    end
    hs = !pipe_p[1];
    ls = pipe_n[1];
    pipe_p[1] = pipe_p[0]; pipe_p[0] = p_in;
    pipe_n[1] = pipe_n[0]; pipe_n[0] = n_in;
    want = hs ? "H" : "L";
    if (m_fault) begin
      if (fault_clear && !hs && !ls) begin
        m_fault = 1'b0; m_line = "Z"; m_gap = 1'b0;
      end
    end else if (hs && ls) begin
      m_fault = 1'b1; m_gap = 1'b0;
      if (m_cnt < CNT_MAX) m_cnt++;
    end else if (!hs && !ls) begin
      m_line = "Z"; m_gap = 1'b0;
    end else if (m_gap) begin
      if (cyc >= m_gap_end) begin
        m_gap = 1'b0; m_line = want;
      end
    end else if (m_line == "Z" || m_line == want || !DEAD_EN) begin
      m_line = want;
    end else begin
      m_gap = 1'b1; m_gap_end = cyc + DEAD_TIME; m_line = "Z";
    end
  endtask

  function automatic logic [VW-1:0] exp_vec();
    logic [1:0] st;
    logic o, oe;
    if (m_fault)                       begin st = 2'b11; o = 1'b0; oe = 1'b0; end
    else if (m_gap || m_line == "Z")   begin st = 2'b00; o = 1'b0; oe = 1'b0; end
    else if (m_line == "H")            begin st = 2'b10; o = 1'b1; oe = 1'b1; end
    else                               begin st = 2'b01; o = 1'b0; oe = 1'b1; end
    return {o, oe, st, m_fault, FAULT_CNT_W'(m_cnt)};
  endfunction

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic set_req(input int code);
    case (code)
      1:       begin p_in = 1'b0; n_in = 1'b0; end
      2:       begin p_in = 1'b1; n_in = 1'b1; end
      3:       begin p_in = 1'b0; n_in = 1'b1; end
      default: begin p_in = 1'b1; n_in = 1'b0; end
    endcase
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_req(int'($urandom_range(0, 3)));
      fault_clear = 1'($urandom_range(0, 1));
      tick();
    end
    checks++;
    if (dut_v !== '0) begin
      errors++;
      $display("FAIL reset_values got %h want %h", dut_v, {VW{1'b0}});
    end
    set_req(0);
    fault_clear = 1'b0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (dut_v !== exp_vec()) begin
        errors++;
        $display("FAIL reset_idle got %h want %h", dut_v, exp_vec());
      end
    end
  endtask

  task automatic test_drive_high();
    set_req(1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (line_oe !== (i == 3) || line_o !== (i == 3)) begin
        errors++;
        $display("FAIL drive_high_latency edge %0d got oe=%b o=%b want oe=%b o=%b",
                 i, line_oe, line_o, (i == 3), (i == 3));
      end
      checks++;
      if (dut_v !== exp_vec()) begin
        errors++;
        $display("FAIL drive_high_model edge %0d got %h want %h", i, dut_v, exp_vec());
      end
    end
  endtask

  task automatic test_break_before_make();
    int gap = 0;
    bit reached = 1'b0;
    logic [1:0] prev_state = state;
    bit direct = 1'b0;
    set_req(2);
    for (int i = 0; i < 40 && !reached; i++) begin
      tick();
      checks++;
      if (dut_v !== exp_vec()) begin
        errors++;
        $display("FAIL bbm_model cycle %0d got %h want %h", i, dut_v, exp_vec());
      end
      if (state === 2'b01) begin
        reached = 1'b1;
        direct = (prev_state === 2'b10);
      end else if (line_oe === 1'b0) begin
        gap++;
      end
      prev_state = state;
    end
    checks++;
    if (!reached || line_oe !== 1'b1 || line_o !== 1'b0) begin
      errors++;
      $display("FAIL bbm_reach_low got state=%b oe=%b o=%b want state=01 oe=1 o=0",
               state, line_oe, line_o);
    end
    checks++;
    if (gap != (DEAD_EN ? DEAD_TIME : 0)) begin
      errors++;
      $display("FAIL bbm_gap_cycles got %0d want %0d", gap, DEAD_EN ? DEAD_TIME : 0);
    end
    checks++;
    if (direct != !DEAD_EN) begin
      errors++;
      $display("FAIL bbm_direct_switch got %0d want %0d", direct, !DEAD_EN);
    end
  endtask

  task automatic test_shoot_through();
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    set_req(0); tick(); tick(); tick();
    set_req(3);
    tick(); tick(); tick();
    checks++;
    if (state !== 2'b11 || fault !== 1'b1 || fault_count !== FAULT_CNT_W'(1) || line_oe !== 1'b0) begin
      errors++;
      $display("FAIL shoot_enter got state=%b fault=%b cnt=%0d oe=%b want 11 1 1 0",
               state, fault, fault_count, line_oe);
    end
    fault_clear = 1'b1; tick(); fault_clear = 1'b0;
    checks++;
    if (state !== 2'b11 || fault !== 1'b1 || fault_count !== FAULT_CNT_W'(1)) begin
      errors++;
      $display("FAIL shoot_clear_blocked got state=%b fault=%b cnt=%0d want 11 1 1",
               state, fault, fault_count);
    end
    set_req(0); tick(); tick();
    checks++;
    if (state !== 2'b11) begin
      errors++;
      $display("FAIL shoot_hold_no_clear got state=%b want 11", state);
    end
    fault_clear = 1'b1; tick(); fault_clear = 1'b0;
    checks++;
    if (state !== 2'b00 || fault !== 1'b0 || fault_count !== FAULT_CNT_W'(1)) begin
      errors++;
      $display("FAIL shoot_cleared got state=%b fault=%b cnt=%0d want 00 0 1",
               state, fault, fault_count);
    end
    fault_clear = 1'b1; tick(); fault_clear = 1'b0;
    checks++;
    if (dut_v !== exp_vec()) begin
      errors++;
      $display("FAIL shoot_clear_in_hiz got %h want %h", dut_v, exp_vec());
    end
  endtask

  task automatic test_reset_midway();
    reset = 1'b1; tick(); reset = 1'b0;
    set_req(1); tick(); tick(); tick(); tick();
    set_req(2); tick(); tick(); tick();
    reset = 1'b1; tick();
    checks++;
    if (dut_v !== '0) begin
      errors++;
      $display("FAIL reset_mid_switch got %h want 0", dut_v);
    end
    reset = 1'b0;
    set_req(3); tick(); tick(); tick(); tick();
    reset = 1'b1; tick();
    checks++;
    if (dut_v !== '0) begin
      errors++;
      $display("FAIL reset_mid_fault got %h want 0", dut_v);
    end
    reset = 1'b0;
    set_req(0);
  endtask

  task automatic test_saturation();
    reset = 1'b1; tick(); reset = 1'b0;
    fault_clear = 1'b1;
    for (int i = 0; i < 620; i++) begin
      set_req((i % 2 == 0) ? 3 : 0);
      tick();
      checks++;
      if (dut_v !== exp_vec()) begin
        errors++;
        $display("FAIL sat_model cycle %0d got %h want %h", i, dut_v, exp_vec());
      end
    end
    set_req(0); tick(); tick(); tick();
    fault_clear = 1'b0; tick();
    checks++;
    if (fault_count !== FAULT_CNT_W'(CNT_MAX) || state !== 2'b00) begin
      errors++;
      $display("FAIL sat_count got cnt=%0d state=%b want cnt=%0d state=00",
               fault_count, state, CNT_MAX);
    end
  endtask

  task automatic test_random();
    int r;
    reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        r = int'($urandom_range(0, 9));
        set_req(r < 3 ? 0 : (r < 6 ? 1 : (r < 9 ? 2 : 3)));
      end
      fault_clear = ($urandom_range(0, 7) == 0);
      reset = ($urandom_range(0, 99) == 0);
      tick();
      checks++;
      if (dut_v !== exp_vec()) begin
        errors++;
        $display("FAIL random_model cycle %0d got %h want %h", i, dut_v, exp_vec());
      end
    end
    reset = 1'b0;
    fault_clear = 1'b0;
  endtask

  initial begin
    test_reset();
    test_drive_high();
    test_break_before_make();
    test_shoot_through();
    test_reset_midway();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
